// File: rtl/mem_reg_sb.sv
// mem_reg_sb: register file with a per-register pending-write scoreboard.
// Two combinational read ports with same-cycle writeback bypass, one write
// port, and a reservation port that counts in-flight writes per register.
// Register 0 is hardwired to zero and is never reserved or reported busy.
module mem_reg_sb #(
   parameter int WORD_LEN     = 16,
   parameter int REG_ADDR_LEN = 3,
   parameter int CNT_LEN      = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [REG_ADDR_LEN-1:0] src1,
   input  logic [REG_ADDR_LEN-1:0] src2,
   output logic [WORD_LEN-1:0]     out1,
   output logic [WORD_LEN-1:0]     out2,
   input  logic [REG_ADDR_LEN-1:0] tgt,
   input  logic [WORD_LEN-1:0]     in,
   input  logic                    writeEn,
   input  logic                    rsv_en,
   input  logic [REG_ADDR_LEN-1:0] rsv_tgt,
   output logic                    busy1,
   output logic                    busy2,
   output logic                    rsv_full
);

   localparam int NREG = 2 ** REG_ADDR_LEN;
   localparam logic [CNT_LEN-1:0] CMAX = {CNT_LEN{1'b1}};
   localparam logic [REG_ADDR_LEN-1:0] R0 = '0;

   logic [WORD_LEN-1:0] mem_reg [NREG];
   logic [CNT_LEN-1:0]  cnt_reg [NREG];

   logic wr_hit;      // writeback to a real register
   logic retire;      // writeback also retires one reservation
   logic rsv_ok;      // reservation accepted this cycle
   logic same_reg;    // accepted reservation and retirement cancel out
   logic [CNT_LEN-1:0] eff1, eff2;

   // Decode write/reserve strobes; register 0 never participates.
   always_comb begin
      wr_hit   = writeEn && (tgt != R0);
      retire   = wr_hit && (cnt_reg[tgt] != '0);
      rsv_full = (rsv_tgt != R0) && (cnt_reg[rsv_tgt] == CMAX);
      rsv_ok   = rsv_en && (rsv_tgt != R0) && !rsv_full;
      same_reg = rsv_ok && retire && (rsv_tgt == tgt);
   end

   // Read ports: zero for R0, bypass from the writeback bus, else storage.
   always_comb begin
      if (src1 == R0)
         out1 = '0;
      else if (wr_hit && (tgt == src1))
         out1 = in;
      else
         out1 = mem_reg[src1];

      if (src2 == R0)
         out2 = '0;
      else if (wr_hit && (tgt == src2))
         out2 = in;
      else
         out2 = mem_reg[src2];
   end

   // Busy reflects the count after a same-cycle retirement on that register.
   always_comb begin
      eff1 = cnt_reg[src1];
      if (retire && (tgt == src1))
         eff1 = cnt_reg[src1] - CNT_LEN'(1);
      eff2 = cnt_reg[src2];
      if (retire && (tgt == src2))
         eff2 = cnt_reg[src2] - CNT_LEN'(1);
      busy1 = (src1 != R0) && (eff1 != '0);
      busy2 = (src2 != R0) && (eff2 != '0);
   end

   // State update: reset clears everything, otherwise write data and
   // adjust the pending counters (saturating via rsv_ok / retire guards).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_reg[i] <= '0;
            cnt_reg[i] <= '0;
         end
      end else begin
         if (wr_hit)
            mem_reg[tgt] <= in;
         if (!same_reg) begin
            if (rsv_ok)
               cnt_reg[rsv_tgt] <= cnt_reg[rsv_tgt] + CNT_LEN'(1);
            if (retire)
               cnt_reg[tgt] <= cnt_reg[tgt] - CNT_LEN'(1);
         end
      end
   end

endmodule
